and16_bist_engine: RTL
======================

// Module: and16_bist_engine
// PURPOSE
//  Built-in self-test engine that drives operand pairs into a 16-bit bitwise-AND chip and checks its result.
//  It applies 4 directed vectors, then NUM_RAND pseudo-random vectors, and compares dut_out against a golden a&b.
//  It counts mismatches and captures the first failing vector.
//  Sits beside the chip under test in hardware, replacing the simulation-only stimulus bench.
// PARAMETERS
//  NUM_RAND  default 16       number of pseudo-random vectors after the directed set (0..65531)
//  SEED_A    default 16'hACE1 LFSR seed for operand A; must be nonzero
//  SEED_B    default 16'h1D2C LFSR seed for operand B; must be nonzero
// PORTS
//  clk           input   1   single clock, rising edge
//  reset         input   1   synchronous, active-high
//  start         input   1   begin a test run (sampled in IDLE or DONE only)
//  dut_a         output  16  operand A to chip under test (registered)
//  dut_b         output  16  operand B to chip under test (registered)
//  dut_out       input   16  combinational result from chip under test
//  busy          output  1   high in DRIVE/SAMPLE
//  done          output  1   high in DONE; held until start or reset
//  pass          output  1   valid when done: 1 iff err_count==0
//  err_count     output  16  mismatching vectors, saturates at 16'hFFFF
//  first_fail_idx output 16  index of first mismatching vector; 16'hFFFF if none
//  fail_a/fail_b output  16  operands of first mismatch; 0 if none
//  fail_out      output  16  dut_out captured at first mismatch; 0 if none
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except first_fail_idx=16'hFFFF; LFSRs reload SEED_A/SEED_B.
//  - Total vectors N = 4 + NUM_RAND. Index 0..3 are directed, in order:
//      (0000,0000) (0000,FFFF) (FFFF,FFFF) (AAAA,5555).
//    Index >= 4 uses the LFSR values.
//  - LFSRs: Fibonacci, taps x^16+x^14+x^13+x^11+1. They advance once per random vector.
//    The vector uses the current value, and the LFSR shifts when the vector loads.
//  - FSM: IDLE -start-> DRIVE; DRIVE -> SAMPLE; SAMPLE -> DRIVE (idx<N-1) or DONE (idx==N-1);
//    DONE -start-> DRIVE.
//  - start from IDLE or DONE clears the results, reseeds the LFSRs and sets idx=0.
//    The results cleared are err_count, first_fail_*, fail_*, pass and done.
//  - DRIVE edge: dut_a/dut_b <= vector[idx]; the operands hold stable through SAMPLE.
//    This gives the chip 1 full cycle to settle.
//  - SAMPLE edge: compare dut_out with dut_a & dut_b (computed internally).
//    On mismatch, err_count++ (saturating).
//    On the first mismatch, also capture idx, dut_a, dut_b and dut_out; idx++.
//  - Latency: if start is accepted at edge t0, done rises at edge t0+2N. busy is high for 2N cycles.
//  - pass is updated with done on the final SAMPLE edge. It is 0 while busy.
//  - start while busy is ignored; the run continues unaffected.
//  - reset mid-run aborts immediately to the reset state. No partial results are retained.
//  - NUM_RAND=0: only the 4 directed vectors run; the LFSRs are unused.
//  - dut_a/dut_b hold the last vector in DONE/IDLE.
// TESTING
//  1. Ideal DUT (out=a&b), NUM_RAND=8, pulse start
//     -> busy 24 cycles, done at t0+24, pass=1, err_count=0, first_fail_idx=FFFF.
//  2. DUT out=a|b, NUM_RAND=0 -> done at t0+8, pass=0, err_count=2,
//     first_fail_idx=1, fail_a=0000, fail_b=FFFF, fail_out=FFFF.
//  3. DUT with out[0] stuck-at-1, NUM_RAND=0 -> err_count=3 (vectors 0,1,3),
//     first_fail_idx=0, fail_out=0001.
//  4. Ideal DUT: assert start again during busy at cycle 5 -> ignored, done still at t0+24.
//     Then start in DONE -> results cleared, an identical second run produces the same dut_a/dut_b sequence.
//  5. Ideal DUT: assert reset at cycle 10 of a run
//     -> next cycle busy=0, done=0, err_count=0, first_fail_idx=FFFF, dut_a=dut_b=0000.
//  6. DUT out=16'h0000, NUM_RAND=65531 -> err_count equals the count of vectors with a&b!=0.
//     Bench computes this via a reference LFSR. There is no wrap past FFFF.

Source files
------------

// File: rtl/and16_bist_engine.sv
// and16_bist_engine: self-test sequencer for a 16-bit bitwise-AND chip.
// Drives 4 directed and NUM_RAND LFSR operand pairs, checks dut_out vs a&b.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           launch a run (honoured in IDLE or DONE only)
//   dut_a, dut_b    registered operands to the chip under test
//   dut_out         combinational chip result
//   busy, done      run in progress / run finished (held)
//   pass            done && no mismatches
//   err_count       saturating mismatch count
//   first_fail_idx  index of first mismatch, 16'hFFFF if none
//   fail_a/b/out    operands and result of first mismatch, 0 if none

module and16_bist_engine #(
   parameter int unsigned NUM_RAND = 16,
   parameter logic [15:0] SEED_A   = 16'hACE1,
   parameter logic [15:0] SEED_B   = 16'h1D2C
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [15:0] dut_a,
   output logic [15:0] dut_b,
   input  logic [15:0] dut_out,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [15:0] first_fail_idx,
   output logic [15:0] fail_a,
   output logic [15:0] fail_b,
   output logic [15:0] fail_out
);

   localparam logic [15:0] LAST_IDX = 16'(NUM_RAND + 3);
   localparam logic [15:0] NO_FAIL  = 16'hFFFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] idx_q, idx_d;
   logic [15:0] lfsr_a_q, lfsr_a_d;
   logic [15:0] lfsr_b_q, lfsr_b_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [15:0] err_q, err_d;
   logic [15:0] ffi_q, ffi_d;
   logic [15:0] fa_q, fa_d;
   logic [15:0] fb_q, fb_d;
   logic [15:0] fo_q, fo_d;
   logic        pass_q, pass_d;

   logic [15:0] vec_a;
   logic [15:0] vec_b;
   logic [15:0] golden;
   logic        mismatch;
   logic        first_hit;

   // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting right.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
   endfunction

   always_comb begin : vector_sel
      vec_a = lfsr_a_q;
      vec_b = lfsr_b_q;
      unique case (idx_q)
         16'd0: begin
            vec_a = 16'h0000;
            vec_b = 16'h0000;
         end
         16'd1: begin
            vec_a = 16'h0000;
            vec_b = 16'hFFFF;
         end
         16'd2: begin
            vec_a = 16'hFFFF;
            vec_b = 16'hFFFF;
         end
         16'd3: begin
            vec_a = 16'hAAAA;
            vec_b = 16'h5555;
         end
         default: begin
         end
      endcase
   end

   assign golden    = a_q & b_q;
   assign mismatch  = (dut_out != golden);
   // err_count only ever moves away from zero, so zero means no failure yet.
   assign first_hit = mismatch && (err_q == 16'd0);

   always_comb begin : next_state
      state_d  = state_q;
      idx_d    = idx_q;
      lfsr_a_d = lfsr_a_q;
      lfsr_b_d = lfsr_b_q;
      a_d      = a_q;
      b_d      = b_q;
      err_d    = err_q;
      ffi_d    = ffi_q;
      fa_d     = fa_q;
      fb_d     = fb_q;
      fo_d     = fo_q;
      pass_d   = pass_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d  = S_DRIVE;
               idx_d    = 16'd0;
               lfsr_a_d = SEED_A;
               lfsr_b_d = SEED_B;
               err_d    = 16'd0;
               ffi_d    = NO_FAIL;
               fa_d     = 16'd0;
               fb_d     = 16'd0;
               fo_d     = 16'd0;
               pass_d   = 1'b0;
            end
         end

         S_DRIVE: begin
            a_d     = vec_a;
            b_d     = vec_b;
            state_d = S_SAMPLE;
            if (idx_q >= 16'd4) begin
               lfsr_a_d = lfsr_step(lfsr_a_q);
               lfsr_b_d = lfsr_step(lfsr_b_q);
            end
         end

         S_SAMPLE: begin
            if (mismatch && (err_q != 16'hFFFF)) begin
               err_d = err_q + 16'd1;
            end
            if (first_hit) begin
               ffi_d = idx_q;
               fa_d  = a_q;
               fb_d  = b_q;
               fo_d  = dut_out;
            end
            idx_d = idx_q + 16'd1;
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
               pass_d  = (err_d == 16'd0);
            end else begin
               state_d = S_DRIVE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= 16'd0;
         lfsr_a_q <= SEED_A;
         lfsr_b_q <= SEED_B;
         a_q      <= 16'd0;
         b_q      <= 16'd0;
         err_q    <= 16'd0;
         ffi_q    <= NO_FAIL;
         fa_q     <= 16'd0;
         fb_q     <= 16'd0;
         fo_q     <= 16'd0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         lfsr_a_q <= lfsr_a_d;
         lfsr_b_q <= lfsr_b_d;
         a_q      <= a_d;
         b_q      <= b_d;
         err_q    <= err_d;
         ffi_q    <= ffi_d;
         fa_q     <= fa_d;
         fb_q     <= fb_d;
         fo_q     <= fo_d;
         pass_q   <= pass_d;
      end
   end

   assign dut_a          = a_q;
   assign dut_b          = b_q;
   assign busy           = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
   assign done           = (state_q == S_DONE);
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_fail_idx = ffi_q;
   assign fail_a         = fa_q;
   assign fail_b         = fb_q;
   assign fail_out       = fo_q;

endmodule
